// File: rtl/axi_register_slice_if.sv
// AXI4 bus bundle used on both sides of axi_register_slice.
// master drives AW/W/AR payloads and B/R readies; slave drives the reverse.
interface axi_register_slice_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_register_slice.sv
// AXI4 register slice: one 2-entry skid buffer per channel, all handshake
// outputs driven from flops so no combinational path crosses the slice.
module axi_register_slice_skid #(
    parameter int WIDTH = 8,
    parameter bit REG   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    generate
        if (REG) begin : g_reg
            state_t           state, state_next;
            logic             ready_q, valid_q;
            logic [WIDTH-1:0] out_q, skid_q;
            logic             push, pop, load_out, load_skid, skid_to_out;

            assign push = in_valid & ready_q;
            assign pop  = valid_q & out_ready;

            // ready/valid are registered copies of the next-state decode
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state   <= EMPTY;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    state   <= state_next;
                    ready_q <= (state_next != FULL);
                    valid_q <= (state_next != EMPTY);
                end
            end

            always_comb begin
                state_next  = state;
                load_out    = 1'b0;
                load_skid   = 1'b0;
                skid_to_out = 1'b0;
                case (state)
                    EMPTY: if (push) begin
                        state_next = ONE;
                        load_out   = 1'b1;
                    end
                    ONE: if (push && pop) begin
                        load_out = 1'b1;
                    end else if (push) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                    FULL: if (pop) begin
                        state_next  = ONE;
                        skid_to_out = 1'b1;
                    end
                    default: state_next = EMPTY;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q  <= '0;
                    skid_q <= '0;
                end else begin
                    if (load_out)         out_q <= in_data;
                    else if (skid_to_out) out_q <= skid_q;
                    if (load_skid)        skid_q <= in_data;
                end
            end

            assign in_ready  = ready_q;
            assign out_valid = valid_q;
            assign out_data  = out_q;
        end else begin : g_wire
            wire unused_clk_rst = ^{clk, rst};
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end
    endgenerate
endmodule

module axi_register_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter bit AW_REG     = 1'b1,
    parameter bit W_REG      = 1'b1,
    parameter bit B_REG      = 1'b1,
    parameter bit AR_REG     = 1'b1,
    parameter bit R_REG      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_register_slice_if.slave  s_axi,
    axi_register_slice_if.master m_axi
);
    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1;

    logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [R_W-1:0]  r_in, r_out;

    assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize,
                    s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot};
    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize,
            m_axi.awburst, m_axi.awlock, m_axi.awcache, m_axi.awprot} = aw_out;

    assign w_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
    assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_out;

    // B and R flow from the RAM side back toward the master
    assign b_in = {m_axi.bid, m_axi.bresp};
    assign {s_axi.bid, s_axi.bresp} = b_out;

    assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize,
                    s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arprot};
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize,
            m_axi.arburst, m_axi.arlock, m_axi.arcache, m_axi.arprot} = ar_out;

    assign r_in = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast};
    assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast} = r_out;

    axi_register_slice_skid #(.WIDTH(AX_W), .REG(AW_REG)) u_aw (
        .clk(clk), .rst(rst),
        .in_data(aw_in), .in_valid(s_axi.awvalid), .in_ready(s_axi.awready),
        .out_data(aw_out), .out_valid(m_axi.awvalid), .out_ready(m_axi.awready)
    );

    axi_register_slice_skid #(.WIDTH(W_W), .REG(W_REG)) u_w (
        .clk(clk), .rst(rst),
        .in_data(w_in), .in_valid(s_axi.wvalid), .in_ready(s_axi.wready),
        .out_data(w_out), .out_valid(m_axi.wvalid), .out_ready(m_axi.wready)
    );

    axi_register_slice_skid #(.WIDTH(B_W), .REG(B_REG)) u_b (
        .clk(clk), .rst(rst),
        .in_data(b_in), .in_valid(m_axi.bvalid), .in_ready(m_axi.bready),
        .out_data(b_out), .out_valid(s_axi.bvalid), .out_ready(s_axi.bready)
    );

    axi_register_slice_skid #(.WIDTH(AX_W), .REG(AR_REG)) u_ar (
        .clk(clk), .rst(rst),
        .in_data(ar_in), .in_valid(s_axi.arvalid), .in_ready(s_axi.arready),
        .out_data(ar_out), .out_valid(m_axi.arvalid), .out_ready(m_axi.arready)
    );

    axi_register_slice_skid #(.WIDTH(R_W), .REG(R_REG)) u_r (
        .clk(clk), .rst(rst),
        .in_data(r_in), .in_valid(m_axi.rvalid), .in_ready(m_axi.rready),
        .out_data(r_out), .out_valid(s_axi.rvalid), .out_ready(s_axi.rready)
    );
endmodule

// File: tb/tb_axi_register_slice.sv
// Directed bench for axi_register_slice: the bench is both AXI master and a
// one-word RAM, with per-channel scoreboards checking order and payload.
module tb_axi_register_slice;
    localparam int DW = 32, AW = 16, SW = 4, IW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_register_slice_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW))
        s_if(), m_if(), s2(), m2();

    axi_register_slice #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .s_axi(s_if.slave), .m_axi(m_if.master)
    );

    axi_register_slice #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
                         .W_REG(1'b0)) dut_byp (
        .clk(clk), .rst(rst), .s_axi(s2.slave), .m_axi(m2.master)
    );

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // packed beat images on each side of the slice
    logic [63:0] aw_s, aw_m, ar_s, ar_m, w_s, w_m, b_s, b_m, r_s, r_m;
    assign aw_s = 64'({s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock, s_if.awcache, s_if.awprot});
    assign aw_m = 64'({m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awlock, m_if.awcache, m_if.awprot});
    assign ar_s = 64'({s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock, s_if.arcache, s_if.arprot});
    assign ar_m = 64'({m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arlock, m_if.arcache, m_if.arprot});
    assign w_s  = 64'({s_if.wdata, s_if.wstrb, s_if.wlast});
    assign w_m  = 64'({m_if.wdata, m_if.wstrb, m_if.wlast});
    assign b_m  = 64'({m_if.bid, m_if.bresp});
    assign b_s  = 64'({s_if.bid, s_if.bresp});
    assign r_m  = 64'({m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast});
    assign r_s  = 64'({s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast});

    logic [63:0] aw_q[$], w_q[$], ar_q[$], b_q[$], r_q[$];
    int aw_pops = 0, w_pops = 0, ar_pops = 0, b_pops = 0, r_pops = 0;
    bit acc_aw, acc_w, acc_ar, acc_b, acc_r;
    logic [31:0] ram_word = '0, last_rdata = '0;
    logic [1:0]  last_rresp = 2'b11, last_bresp = 2'b11;

    // sample handshakes just before the edge, then step one cycle
    task automatic tick();
        #1;
        acc_aw = s_if.awvalid && s_if.awready;
        acc_w  = s_if.wvalid && s_if.wready;
        acc_ar = s_if.arvalid && s_if.arready;
        acc_b  = m_if.bvalid && m_if.bready;
        acc_r  = m_if.rvalid && m_if.rready;
        if (acc_aw) aw_q.push_back(aw_s);
        if (acc_w)  w_q.push_back(w_s);
        if (acc_ar) ar_q.push_back(ar_s);
        if (acc_b)  b_q.push_back(b_m);
        if (acc_r)  r_q.push_back(r_m);
        if (m_if.awvalid && m_if.awready) begin
            aw_pops++;
            if (aw_q.size() == 0) check("aw_q_depth", 64'(aw_q.size()), 64'd1);
            else check("aw_beat", aw_m, aw_q.pop_front());
        end
        if (m_if.wvalid && m_if.wready) begin
            w_pops++;
            ram_word = m_if.wdata;
            if (w_q.size() == 0) check("w_q_depth", 64'(w_q.size()), 64'd1);
            else check("w_beat", w_m, w_q.pop_front());
        end
        if (m_if.arvalid && m_if.arready) begin
            ar_pops++;
            if (ar_q.size() == 0) check("ar_q_depth", 64'(ar_q.size()), 64'd1);
            else check("ar_beat", ar_m, ar_q.pop_front());
        end
        if (s_if.bvalid && s_if.bready) begin
            b_pops++;
            last_bresp = s_if.bresp;
            if (b_q.size() == 0) check("b_q_depth", 64'(b_q.size()), 64'd1);
            else check("b_beat", b_s, b_q.pop_front());
        end
        if (s_if.rvalid && s_if.rready) begin
            r_pops++;
            last_rdata = s_if.rdata;
            last_rresp = s_if.rresp;
            if (r_q.size() == 0) check("r_q_depth", 64'(r_q.size()), 64'd1);
            else check("r_beat", r_s, r_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input bit v, input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len);
        s_if.awvalid = v; s_if.awid = id; s_if.awaddr = addr; s_if.awlen = len;
        s_if.awsize = 3'd2; s_if.awburst = 2'd1; s_if.awlock = 1'b0; s_if.awcache = 4'd3; s_if.awprot = 3'd2;
    endtask
    task automatic drive_ar(input bit v, input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len);
        s_if.arvalid = v; s_if.arid = id; s_if.araddr = addr; s_if.arlen = len;
        s_if.arsize = 3'd2; s_if.arburst = 2'd1; s_if.arlock = 1'b0; s_if.arcache = 4'd3; s_if.arprot = 3'd1;
    endtask
    task automatic drive_w(input bit v, input logic [31:0] d, input bit last);
        s_if.wvalid = v; s_if.wdata = d; s_if.wstrb = 4'hF; s_if.wlast = last;
    endtask
    task automatic drive_b(input bit v, input logic [7:0] id, input logic [1:0] resp);
        m_if.bvalid = v; m_if.bid = id; m_if.bresp = resp;
    endtask
    task automatic drive_r(input bit v, input logic [7:0] id, input logic [31:0] d, input logic [1:0] resp, input bit last);
        m_if.rvalid = v; m_if.rid = id; m_if.rdata = d; m_if.rresp = resp; m_if.rlast = last;
    endtask

    // once a master-facing R beat or RAM-facing W beat is stalled, it must hold
    logic        r_hold = 1'b0, w_hold = 1'b0;
    logic [63:0] r_prev = '0, w_prev = '0;
    always @(negedge clk) begin
        if (rst) begin
            r_hold = 1'b0;
            w_hold = 1'b0;
        end else begin
            if (r_hold) check("r_stable", {s_if.rvalid, r_s[62:0]}, {1'b1, r_prev[62:0]});
            if (w_hold) check("w_stable", {m_if.wvalid, w_m[62:0]}, {1'b1, w_prev[62:0]});
            r_hold = s_if.rvalid && !s_if.rready;
            r_prev = r_s;
            w_hold = m_if.wvalid && !m_if.wready;
            w_prev = w_m;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, k, c, first, last, base, pb;
        bit aw_done;

        drive_aw(0, 0, 0, 0); drive_ar(0, 0, 0, 0); drive_w(0, 0, 0);
        drive_b(0, 0, 0); drive_r(0, 0, 0, 0, 0);
        s_if.bready = 1'b0; s_if.rready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
        {s2.awid, s2.awaddr, s2.awlen, s2.awsize, s2.awburst, s2.awlock, s2.awcache, s2.awprot, s2.awvalid} = '0;
        {s2.wdata, s2.wstrb, s2.wlast, s2.wvalid, s2.bready, s2.rready} = '0;
        {s2.arid, s2.araddr, s2.arlen, s2.arsize, s2.arburst, s2.arlock, s2.arcache, s2.arprot, s2.arvalid} = '0;
        {m2.awready, m2.wready, m2.arready, m2.bid, m2.bresp, m2.bvalid} = '0;
        {m2.rid, m2.rdata, m2.rresp, m2.rlast, m2.rvalid} = '0;

        // reset held for 3 cycles
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_valids", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}), 64'd0);
            check("rst_awready", 64'(s_if.awready), 64'd0);
        end
        rst = 1'b0;
        #1 check("awready_at_release", 64'(s_if.awready), 64'd0);
        @(posedge clk); #1;
        check("awready_1edge", 64'(s_if.awready), 64'd1);
        m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
        s_if.bready = 1'b1; s_if.rready = 1'b1;

        // 16-beat INCR write streaming at full rate
        i = 0; c = 0; aw_done = 0; first = -1; last = -1; base = w_pops;
        while (w_pops - base < 16 && c < 40) begin
            drive_aw(!aw_done, 8'h05, 16'h0100, 8'd15);
            drive_w(i < 16, 32'(i), i == 15);
            if (c == 0) check("w_lat_cycle0", 64'(m_if.wvalid), 64'd0);
            if (c == 1) check("w_lat_cycle1", 64'(m_if.wvalid), 64'd1);
            pb = w_pops;
            tick();
            if (acc_aw) aw_done = 1;
            if (acc_w) i++;
            if (w_pops != pb) begin
                if (first < 0) first = c;
                last = c;
            end
            c++;
        end
        drive_aw(0, 0, 0, 0); drive_w(0, 0, 0);
        check("w_count", 64'(w_pops - base), 64'd16);
        check("w_first_cycle", 64'(first), 64'd1);
        check("w_span", 64'(last - first), 64'd15);
        check("aw_count", 64'(aw_pops), 64'd1);

        // 4-beat read with the master refusing R: slice stalls holding 2 beats
        drive_ar(1, 8'h03, 16'h0200, 8'd3);
        c = 0; base = ar_pops;
        while (ar_pops == base && c < 10) begin
            tick();
            if (acc_ar) drive_ar(0, 0, 0, 0);
            c++;
        end
        check("ar_bp_count", 64'(ar_pops - base), 64'd1);
        k = 0; c = 0; base = r_pops;
        while (r_pops - base < 4 && c < 30) begin
            s_if.rready = (c >= 6);
            drive_r(k < 4, 8'h03, 32'(32'hA0 + k), 2'd0, k == 3);
            if (c == 5) begin
                check("r_stall_ready", 64'(m_if.rready), 64'd0);
                check("r_stall_depth", 64'(r_q.size()), 64'd2);
                check("r_stall_valid", 64'(s_if.rvalid), 64'd1);
            end
            tick();
            if (acc_r) k++;
            c++;
        end
        drive_r(0, 0, 0, 0, 0);
        s_if.rready = 1'b1;
        check("r_bp_count", 64'(r_pops - base), 64'd4);

        // push and pop together every cycle: output register shows beat k at k+1
        base = ar_pops;
        for (int c4 = 0; c4 < 10; c4++) begin
            drive_ar(c4 < 9, 8'h04, 16'(16'h0300 + c4 * 4), 8'd0);
            if (c4 >= 1) begin
                check("ar_one_addr", 64'(m_if.araddr), 64'(16'h0300 + (c4 - 1) * 4));
                check("ar_one_valid", 64'(m_if.arvalid), 64'd1);
            end
            if (c4 < 9) check("ar_one_ready", 64'(s_if.arready), 64'd1);
            tick();
        end
        drive_ar(0, 0, 0, 0);
        tick();
        check("ar_one_count", 64'(ar_pops - base), 64'd9);

        // reset in the middle of an 8-beat write
        drive_aw(1, 8'h06, 16'h0000, 8'd7);
        tick();
        drive_aw(0, 0, 0, 0);
        for (int j = 0; j < 3; j++) begin
            drive_w(1, 32'(32'h1000 + j), 1'b0);
            tick();
        end
        check("mid_wvalid", 64'(m_if.wvalid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valids", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}), 64'd0);
        check("async_rst_readies", 64'({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}), 64'd0);
        aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
        drive_w(0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // post-reset write then read back through the slice
        drive_aw(1, 8'h07, 16'h0040, 8'd0);
        drive_w(1, 32'hDEADBEEF, 1'b1);
        c = 0; base = w_pops; pb = aw_pops;
        while ((w_pops == base || aw_pops == pb) && c < 10) begin
            tick();
            if (acc_aw) drive_aw(0, 0, 0, 0);
            if (acc_w) drive_w(0, 0, 0);
            c++;
        end
        check("wr_w_count", 64'(w_pops - base), 64'd1);
        check("wr_aw_count", 64'(aw_pops - pb), 64'd1);
        drive_b(1, 8'h07, 2'd0);
        c = 0; base = b_pops;
        while (b_pops == base && c < 10) begin
            tick();
            if (acc_b) drive_b(0, 0, 0);
            c++;
        end
        check("b_count", 64'(b_pops - base), 64'd1);
        check("bresp", 64'(last_bresp), 64'd0);
        drive_ar(1, 8'h07, 16'h0040, 8'd0);
        c = 0; base = ar_pops;
        while (ar_pops == base && c < 10) begin
            tick();
            if (acc_ar) drive_ar(0, 0, 0, 0);
            c++;
        end
        check("rd_ar_count", 64'(ar_pops - base), 64'd1);
        drive_r(1, 8'h07, ram_word, 2'd0, 1'b1);
        c = 0; base = r_pops;
        while (r_pops == base && c < 10) begin
            tick();
            if (acc_r) drive_r(0, 0, 0, 0, 0);
            c++;
        end
        check("readback_data", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
        check("rresp", 64'(last_rresp), 64'd0);

        // W passthrough build: W is combinational, AW still registered
        m2.wready = 1'b1; m2.awready = 1'b0;
        s2.wvalid = 1'b1; s2.wdata = 32'h55AA_0F0F; s2.wstrb = 4'hF; s2.wlast = 1'b1;
        s2.awvalid = 1'b1; s2.awaddr = 16'h0080;
        #1;
        check("byp_wvalid", 64'(m2.wvalid), 64'd1);
        check("byp_wdata", 64'(m2.wdata), 64'h55AA_0F0F);
        check("byp_aw_same_cycle", 64'(m2.awvalid), 64'd0);
        m2.wready = 1'b0;
        #1 check("byp_wready", 64'(s2.wready), 64'd0);
        @(posedge clk); #1;
        s2.awvalid = 1'b0; s2.wvalid = 1'b0;
        check("byp_aw_next_cycle", 64'(m2.awvalid), 64'd1);
        check("byp_aw_addr", 64'(m2.awaddr), 64'h0080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
